// File: rtl/pair_feeder_pkg.sv
// Shared types and constants for the pair feeder: FSM state enums, pair layout, widths.
package pair_feeder_pkg;

    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned DIM_W     = 4;
    localparam int unsigned PAIR_W    = 2 * DIM_W;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_WAIT = 2'd2
    } out_state_e;

    // Upper nibble is the first dimension, lower nibble the second.
    typedef struct packed {
        logic [DIM_W-1:0] a;
        logic [DIM_W-1:0] b;
    } pair_t;

    function automatic logic pair_has_zero(input pair_t p);
        return (p.a == '0) || (p.b == '0);
    endfunction

endpackage

// File: rtl/pair_feeder_if.sv
// Source and perimeter-stage handshake signals plus the delivery/drop counters.
interface pair_feeder_if
    import pair_feeder_pkg::*;
();

    logic [PAIR_W-1:0] x;
    logic              dav_in_;
    logic              rfd_in;
    logic [DIM_W-1:0]  a;
    logic [DIM_W-1:0]  b;
    logic              dav_;
    logic              rfd;
    logic [CNT_W-1:0]  sent;
    logic [CNT_W-1:0]  dropped;

    modport master (
        output x, dav_in_, rfd,
        input  rfd_in, a, b, dav_, sent, dropped
    );

    modport slave (
        input  x, dav_in_, rfd,
        output rfd_in, a, b, dav_, sent, dropped
    );

endinterface

// File: rtl/pair_fifo.sv
// Pair FIFO with power-of-two depth; full is judged on the pre-edge occupancy.
module pair_fifo
    import pair_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push_i,
    input  logic  pop_i,
    input  pair_t wdata_i,
    output pair_t head_c,
    output logic  full_c,
    output logic  empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pair_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           wr_en;
    logic           rd_en;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);
    assign head_c  = mem_q[rd_ptr_q];

    assign wr_en = push_i && !full_c;
    assign rd_en = pop_i && !empty_c;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pair_feeder.sv
// Accepts packed dimension pairs over a 4-phase handshake, drops zero-size pairs,
// buffers the rest and replays them in order over a second 4-phase handshake.
module pair_feeder
    import pair_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input logic          clock,
    input logic          reset,
    pair_feeder_if.slave pif
);

    in_state_e        in_q, in_d;
    out_state_e       out_q, out_d;
    logic             rfd_in_q, rfd_in_d;
    logic             dav_q, dav_d;
    logic [DIM_W-1:0] a_q, a_d;
    logic [DIM_W-1:0] b_q, b_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    pair_t            x_pair;
    pair_t            head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign x_pair = pair_t'(pif.x);

    assign pif.rfd_in  = rfd_in_q;
    assign pif.dav_    = dav_q;
    assign pif.a       = a_q;
    assign pif.b       = b_q;
    assign pif.sent    = sent_q;
    assign pif.dropped = dropped_q;

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (x_pair),
        .head_c  (head),
        .full_c  (full),
        .empty_c (empty)
    );

    // Source side: capture on falling dav_in_, hold the ack until dav_in_ rises.
    always_comb begin
        in_d      = in_q;
        rfd_in_d  = rfd_in_q;
        dropped_d = dropped_q;
        push      = 1'b0;
        case (in_q)
            IN_IDLE: begin
                if (!pif.dav_in_ && !full) begin
                    in_d     = IN_ACK;
                    rfd_in_d = 1'b0;
                    if (pair_has_zero(x_pair)) begin
                        dropped_d = dropped_q + CNT_W'(1);
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            IN_ACK: begin
                if (pif.dav_in_) begin
                    in_d     = IN_IDLE;
                    rfd_in_d = 1'b1;
                end
            end
        endcase
    end

    // Perimeter side: present the head, pop on rfd low, wait for rfd to return high.
    always_comb begin
        out_d  = out_q;
        dav_d  = dav_q;
        a_d    = a_q;
        b_d    = b_q;
        sent_d = sent_q;
        pop    = 1'b0;
        case (out_q)
            OUT_IDLE: begin
                if (!empty) begin
                    out_d = OUT_REQ;
                    dav_d = 1'b0;
                    a_d   = head.a;
                    b_d   = head.b;
                end
            end
            OUT_REQ: begin
                if (!pif.rfd) begin
                    out_d  = OUT_WAIT;
                    dav_d  = 1'b1;
                    pop    = 1'b1;
                    sent_d = sent_q + CNT_W'(1);
                end
            end
            OUT_WAIT: begin
                if (pif.rfd) begin
                    out_d = OUT_IDLE;
                end
            end
            default: begin
                out_d = OUT_IDLE;
                dav_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_q      <= IN_IDLE;
            out_q     <= OUT_IDLE;
            rfd_in_q  <= 1'b1;
            dav_q     <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            sent_q    <= '0;
            dropped_q <= '0;
        end else begin
            in_q      <= in_d;
            out_q     <= out_d;
            rfd_in_q  <= rfd_in_d;
            dav_q     <= dav_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sent_q    <= sent_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: tb/tb_pair_feeder.sv
// Directed bench for pair_feeder: vector table of single transactions plus
// hand-written backpressure, simultaneous push/pop, reset and wrap sequences.
module tb_pair_feeder;
    import pair_feeder_pkg::*;

    logic clock = 1'b0;
    logic reset;

    pair_feeder_if pif ();

    pair_feeder #(
        .DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pif   (pif)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_sent;
    int exp_drop;

    typedef struct {
        logic [7:0] x;
        logic [3:0] ea;
        logic [3:0] eb;
        bit         drop;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pif.dav_in_ = 1'b1;
        pif.rfd     = 1'b1;
        pif.x       = 8'h00;
        step();
        reset    = 1'b0;
        exp_sent = 0;
        exp_drop = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rfd_in"},  int'(pif.rfd_in), 1);
        check({tag, "_dav"},     int'(pif.dav_), 1);
        check({tag, "_a"},       int'(pif.a), 0);
        check({tag, "_b"},       int'(pif.b), 0);
        check({tag, "_sent"},    int'(pif.sent), 0);
        check({tag, "_dropped"}, int'(pif.dropped), 0);
        check({tag, "_occ"},     int'(dut.u_fifo.count_q), 0);
    endtask

    // Full 4-phase source transfer with a bounded wait for the acknowledge.
    task automatic send_src(input logic [7:0] v);
        bit ok;
        ok          = 1'b0;
        pif.x       = v;
        pif.dav_in_ = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pif.rfd_in == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("src_ack", int'(ok), 1);
        pif.dav_in_ = 1'b1;
        step();
    endtask

    // Full 4-phase downstream transfer; checks the presented pair and sent count.
    task automatic recv(input logic [3:0] ea, input logic [3:0] eb);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pif.dav_ == 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("dst_req", int'(ok), 1);
        if (ok) begin
            check("dst_a", int'(pif.a), int'(ea));
            check("dst_b", int'(pif.b), int'(eb));
            pif.rfd = 1'b0;
            step();
            exp_sent = (exp_sent + 1) % 256;
            check("sent", int'(pif.sent), exp_sent);
            check("dav_released", int'(pif.dav_), 1);
            pif.rfd = 1'b1;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;

        vecs[0] = '{x: 8'h07, ea: 4'h0, eb: 4'h0, drop: 1'b1};
        vecs[1] = '{x: 8'h40, ea: 4'h0, eb: 4'h0, drop: 1'b1};
        vecs[2] = '{x: 8'h35, ea: 4'h3, eb: 4'h5, drop: 1'b0};
        vecs[3] = '{x: 8'hA1, ea: 4'hA, eb: 4'h1, drop: 1'b0};
        vecs[4] = '{x: 8'hFF, ea: 4'hF, eb: 4'hF, drop: 1'b0};
        vecs[5] = '{x: 8'h00, ea: 4'h0, eb: 4'h0, drop: 1'b1};
        vecs[6] = '{x: 8'h1F, ea: 4'h1, eb: 4'hF, drop: 1'b0};
        vecs[7] = '{x: 8'hF0, ea: 4'h0, eb: 4'h0, drop: 1'b1};
        vecs[8] = '{x: 8'h88, ea: 4'h8, eb: 4'h8, drop: 1'b0};

        // Reset state
        reset       = 1'b1;
        pif.dav_in_ = 1'b1;
        pif.rfd     = 1'b1;
        pif.x       = 8'h00;
        step();
        step();
        check_reset_state("por");
        reset    = 1'b0;
        exp_sent = 0;
        exp_drop = 0;

        // Single pair with exact cycle timing
        pif.x       = 8'h35;
        pif.dav_in_ = 1'b0;
        step();
        check("s1_ack", int'(pif.rfd_in), 0);
        check("s1_dav_not_yet", int'(pif.dav_), 1);
        pif.dav_in_ = 1'b1;
        step();
        check("s1_dav_low", int'(pif.dav_), 0);
        check("s1_a", int'(pif.a), 3);
        check("s1_b", int'(pif.b), 5);
        check("s1_rfd_in_back", int'(pif.rfd_in), 1);
        step();
        check("s1_a_stable", int'(pif.a), 3);
        check("s1_dav_held", int'(pif.dav_), 0);
        pif.rfd = 1'b0;
        step();
        check("s1_sent", int'(pif.sent), 1);
        check("s1_dav_high", int'(pif.dav_), 1);
        pif.rfd = 1'b1;
        step();
        step();
        check("s1_a_hold", int'(pif.a), 3);
        check("s1_idle_dav", int'(pif.dav_), 1);

        // Table: drops and deliveries from a fresh reset
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send_src(vecs[i].x);
            if (vecs[i].drop) begin
                exp_drop++;
                step();
                step();
                check("tbl_no_dav", int'(pif.dav_), 1);
                check("tbl_sent", int'(pif.sent), exp_sent);
            end else begin
                recv(vecs[i].ea, vecs[i].eb);
            end
            check("tbl_dropped", int'(pif.dropped), exp_drop);
        end

        // Backpressure: fifth pair waits until a slot frees
        do_reset();
        send_src(8'h11);
        send_src(8'h22);
        send_src(8'h33);
        send_src(8'h44);
        check("bp_occ_full", int'(dut.u_fifo.count_q), 4);
        pif.x       = 8'h55;
        pif.dav_in_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_stall", int'(pif.rfd_in), 1);
        end
        check("bp_head_a", int'(pif.a), 1);
        check("bp_head_dav", int'(pif.dav_), 0);
        pif.rfd = 1'b0;
        step();
        check("bp_full_before_pop", int'(pif.rfd_in), 1);
        check("bp_occ_after_pop", int'(dut.u_fifo.count_q), 3);
        exp_sent = 1;
        pif.rfd = 1'b1;
        step();
        check("bp_captured", int'(pif.rfd_in), 0);
        check("bp_occ_refill", int'(dut.u_fifo.count_q), 4);
        pif.dav_in_ = 1'b1;
        step();
        recv(4'h2, 4'h2);
        recv(4'h3, 4'h3);
        recv(4'h4, 4'h4);
        recv(4'h5, 4'h5);
        check("bp_occ_drained", int'(dut.u_fifo.count_q), 0);

        // Push and pop on the same edge at occupancy 2
        do_reset();
        send_src(8'h11);
        send_src(8'h22);
        check("sim_occ_pre", int'(dut.u_fifo.count_q), 2);
        check("sim_head", int'(pif.a), 1);
        pif.x       = 8'h33;
        pif.dav_in_ = 1'b0;
        pif.rfd     = 1'b0;
        step();
        check("sim_occ_post", int'(dut.u_fifo.count_q), 2);
        check("sim_ack", int'(pif.rfd_in), 0);
        check("sim_sent", int'(pif.sent), 1);
        exp_sent = 1;
        pif.dav_in_ = 1'b1;
        pif.rfd     = 1'b1;
        step();
        recv(4'h2, 4'h2);
        recv(4'h3, 4'h3);
        check("sim_occ_end", int'(dut.u_fifo.count_q), 0);

        // Reset during OUT_REQ with three pairs queued
        do_reset();
        send_src(8'h07);
        send_src(8'h11);
        send_src(8'h22);
        send_src(8'h33);
        check("rst_pre_dav", int'(pif.dav_), 0);
        check("rst_pre_drop", int'(pif.dropped), 1);
        check("rst_pre_occ", int'(dut.u_fifo.count_q), 3);
        reset = 1'b1;
        step();
        check_reset_state("mid");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        check("rst_no_stale_dav", int'(pif.dav_), 1);
        check("rst_no_stale_a", int'(pif.a), 0);
        check("rst_sent_zero", int'(pif.sent), 0);

        // 256 deliveries wrap the sent counter
        do_reset();
        v = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = {4'(i % 15 + 1), 4'((i / 15) % 15 + 1)};
            send_src(v);
            recv(v[7:4], v[3:0]);
        end
        check("wrap_sent", int'(pif.sent), 0);
        check("wrap_last_a", int'(pif.a), int'(v[7:4]));
        check("wrap_last_b", int'(pif.b), int'(v[3:0]));
        check("wrap_dropped", int'(pif.dropped), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
